// File: rtl/reg_bank_pkg.sv
// Shared definitions for the parametrised register bank: reset image and read-source select.
// Consumers import reg_bank_pkg::*.
package reg_bank_pkg;

  localparam int unsigned RST_R2      = 2;
  localparam int unsigned RST_R3      = 349;
  localparam int unsigned RST_DEFAULT = 0;

  // Address the processor top ties onto dbg_addr (replaces the old fixed debug tap).
  localparam int unsigned DBG_TAP_ADDR = 13;

  typedef enum logic [0:0] {
    SRC_ARRAY  = 1'b0,
    SRC_BYPASS = 1'b1
  } rd_src_e;

  function automatic logic [63:0] reset_value(input int idx);
    case (idx)
      2:       return 64'(RST_R2);
      3:       return 64'(RST_R3);
      default: return 64'(RST_DEFAULT);
    endcase
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending vector: reserve sets, write clears, set wins on a same-cycle collision.
// CLEAR_VISIBLE selects whether queries see this cycle's clear (bypass build) or only its set.
module reg_scoreboard
  import reg_bank_pkg::*;
#(
  parameter int NUM_REGS      = 16,
  parameter bit CLEAR_VISIBLE = 1'b1,
  localparam int AW           = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic [AW-1:0] q1_addr,
  input  logic [AW-1:0] q2_addr,
  output logic          q1_busy,
  output logic          q2_busy
);

  logic [NUM_REGS-1:0] r_pending;
  logic [NUM_REGS-1:0] w_set;
  logic [NUM_REGS-1:0] w_clr;
  logic [NUM_REGS-1:0] w_pending_next;
  logic [NUM_REGS-1:0] w_query;

  // Slot 0 is the zero register and can never become pending.
  assign w_set[0] = 1'b0;
  assign w_clr[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_slot
      assign w_set[gi] = set_en && (set_addr == AW'(gi));
      assign w_clr[gi] = clr_en && (clr_addr == AW'(gi));
    end
  endgenerate

  assign w_pending_next = (r_pending & ~w_clr) | w_set;
  assign w_query        = CLEAR_VISIBLE ? w_pending_next : (r_pending | w_set);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_next;
    end
  end

  assign q1_busy = w_query[q1_addr];
  assign q2_busy = w_query[q2_addr];

endmodule

// File: rtl/reg_bank_param.sv
// Parametrised register file: two registered read ports with busy/valid, one write port,
// zero register R0, registered debug port. Define REG_BANK_BYPASS_EN for write-to-read forwarding.
module reg_bank_param
  import reg_bank_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int DATA_W   = 32,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [AW-1:0]     rs1_addr,
  input  logic [AW-1:0]     rs2_addr,
  output logic [DATA_W-1:0] data1,
  output logic [DATA_W-1:0] data2,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              rd_valid,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [AW-1:0]     rsv_addr,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

`ifdef REG_BANK_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [DATA_W-1:0] r_mem [NUM_REGS];
  logic [DATA_W-1:0] r_data1;
  logic [DATA_W-1:0] r_data2;
  logic [DATA_W-1:0] r_dbg_data;
  logic              r_rs1_busy;
  logic              r_rs2_busy;
  logic              r_rd_valid;

  logic              w_wr_live;
  logic              w_rsv_live;
  rd_src_e           w_rs1_src;
  rd_src_e           w_rs2_src;
  rd_src_e           w_dbg_src;
  logic [DATA_W-1:0] w_rd1_val;
  logic [DATA_W-1:0] w_rd2_val;
  logic [DATA_W-1:0] w_dbg_val;
  logic              w_rs1_busy;
  logic              w_rs2_busy;

  assign w_wr_live  = wr_en && (wr_addr != '0);
  assign w_rsv_live = rsv_en && (rsv_addr != '0);

  // Storage is flop-based because the whole array must load a reset image asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_mem[i] <= DATA_W'(reset_value(i));
      end
    end else if (w_wr_live) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  assign w_rs1_src = (BYPASS && w_wr_live && (wr_addr == rs1_addr)) ? SRC_BYPASS : SRC_ARRAY;
  assign w_rs2_src = (BYPASS && w_wr_live && (wr_addr == rs2_addr)) ? SRC_BYPASS : SRC_ARRAY;
  assign w_dbg_src = (BYPASS && w_wr_live && (wr_addr == dbg_addr)) ? SRC_BYPASS : SRC_ARRAY;

  assign w_rd1_val = (w_rs1_src == SRC_BYPASS) ? wr_data : r_mem[rs1_addr];
  assign w_rd2_val = (w_rs2_src == SRC_BYPASS) ? wr_data : r_mem[rs2_addr];
  assign w_dbg_val = (w_dbg_src == SRC_BYPASS) ? wr_data : r_mem[dbg_addr];

  reg_scoreboard #(
    .NUM_REGS      (NUM_REGS),
    .CLEAR_VISIBLE (BYPASS)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (w_rsv_live),
    .set_addr (rsv_addr),
    .clr_en   (w_wr_live),
    .clr_addr (wr_addr),
    .q1_addr  (rs1_addr),
    .q2_addr  (rs2_addr),
    .q1_busy  (w_rs1_busy),
    .q2_busy  (w_rs2_busy)
  );

  // Read outputs hold between requests; rd_valid marks the cycle they were refreshed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data1    <= '0;
      r_data2    <= '0;
      r_rs1_busy <= 1'b0;
      r_rs2_busy <= 1'b0;
      r_rd_valid <= 1'b0;
      r_dbg_data <= '0;
    end else begin
      r_rd_valid <= rd_en;
      r_dbg_data <= w_dbg_val;
      if (rd_en) begin
        r_data1    <= w_rd1_val;
        r_data2    <= w_rd2_val;
        r_rs1_busy <= w_rs1_busy;
        r_rs2_busy <= w_rs2_busy;
      end
    end
  end

  assign data1    = r_data1;
  assign data2    = r_data2;
  assign rs1_busy = r_rs1_busy;
  assign rs2_busy = r_rs2_busy;
  assign rd_valid = r_rd_valid;
  assign dbg_data = r_dbg_data;

endmodule

// File: tb/tb_reg_bank_param.sv
// Directed bench for reg_bank_param: a default 16x32 instance plus a 32x64 instance.
// Expectations follow REG_BANK_BYPASS_EN when it is defined for the build.
module tb_reg_bank_param;

`ifdef REG_BANK_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;

  logic        rd_en, wr_en, rsv_en;
  logic [3:0]  rs1_addr, rs2_addr, wr_addr, rsv_addr, dbg_addr;
  logic [31:0] wr_data;
  logic [31:0] data1, data2, dbg_data;
  logic        rs1_busy, rs2_busy, rd_valid;

  logic        rd_en_w, wr_en_w, rsv_en_w;
  logic [4:0]  rs1_addr_w, rs2_addr_w, wr_addr_w, rsv_addr_w, dbg_addr_w;
  logic [63:0] wr_data_w;
  logic [63:0] data1_w, data2_w, dbg_data_w;
  logic        rs1_busy_w, rs2_busy_w, rd_valid_w;

  int n_checks = 0;
  int n_fail   = 0;

  reg_bank_param u_dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .data1(data1), .data2(data2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rd_valid(rd_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  reg_bank_param #(.NUM_REGS(32), .DATA_W(64)) u_dut_w (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en_w), .rs1_addr(rs1_addr_w), .rs2_addr(rs2_addr_w),
    .data1(data1_w), .data2(data2_w), .rs1_busy(rs1_busy_w), .rs2_busy(rs2_busy_w),
    .rd_valid(rd_valid_w), .wr_en(wr_en_w), .wr_addr(wr_addr_w), .wr_data(wr_data_w),
    .rsv_en(rsv_en_w), .rsv_addr(rsv_addr_w), .dbg_addr(dbg_addr_w), .dbg_data(dbg_data_w)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    rd_en = 1'b0; wr_en = 1'b0; rsv_en = 1'b0;
    rs1_addr = '0; rs2_addr = '0; wr_addr = '0; rsv_addr = '0; wr_data = '0;
    rd_en_w = 1'b0; wr_en_w = 1'b0; rsv_en_w = 1'b0;
    rs1_addr_w = '0; rs2_addr_w = '0; wr_addr_w = '0; rsv_addr_w = '0; wr_data_w = '0;
  endtask

  // Advance one edge and sample 1 time unit later; one log line per transaction.
  task automatic tick();
    @(posedge clk);
    #1;
    $display("txn t=%0t rv=%0b d1=%0h d2=%0h b1=%0b b2=%0b dbg=%0h | w rv=%0b d1=%0h d2=%0h dbg=%0h",
             $time, rd_valid, data1, data2, rs1_busy, rs2_busy, dbg_data,
             rd_valid_w, data1_w, data2_w, dbg_data_w);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    dbg_addr = 4'd13;
    dbg_addr_w = 5'd31;
    tick();
    tick();
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %0b want 0", rd_valid); end
    n_checks++; if (data1 !== 32'd0) begin n_fail++; $display("FAIL reset_data1: got %0h want 0", data1); end
    n_checks++; if (dbg_data !== 32'd0) begin n_fail++; $display("FAIL reset_dbg: got %0h want 0", dbg_data); end
    rst_n = 1'b1;
    rd_en = 1'b1; rs1_addr = 4'd2; rs2_addr = 4'd3; dbg_addr = 4'd3;
    tick();
    n_checks++; if (data1 !== 32'd2) begin n_fail++; $display("FAIL reset_r2: got %0h want 2", data1); end
    n_checks++; if (data2 !== 32'd349) begin n_fail++; $display("FAIL reset_r3: got %0h want 15d", data2); end
    n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL reset_read_valid: got %0b want 1", rd_valid); end
    n_checks++; if ({rs1_busy, rs2_busy} !== 2'b00) begin n_fail++; $display("FAIL reset_busy: got %0b%0b want 00", rs1_busy, rs2_busy); end
    n_checks++; if (dbg_data !== 32'd349) begin n_fail++; $display("FAIL reset_dbg_r3: got %0h want 15d", dbg_data); end
    rd_en = 1'b0; rs1_addr = 4'd3;
    dbg_addr = 4'd13;
    tick();
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL idle_rd_valid: got %0b want 0", rd_valid); end
    n_checks++; if (data1 !== 32'd2) begin n_fail++; $display("FAIL idle_hold_data1: got %0h want 2", data1); end
  endtask

  task automatic test_r0();
    idle();
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'hDEADBEEF;
    rsv_en = 1'b1; rsv_addr = 4'd0;
    rd_en = 1'b1; rs1_addr = 4'd0; rs2_addr = 4'd0;
    tick();
    n_checks++; if (data1 !== 32'd0) begin n_fail++; $display("FAIL r0_same_cycle: got %0h want 0", data1); end
    n_checks++; if (rs1_busy !== 1'b0) begin n_fail++; $display("FAIL r0_busy_same: got %0b want 0", rs1_busy); end
    idle();
    rd_en = 1'b1; rs1_addr = 4'd0; rs2_addr = 4'd2;
    tick();
    n_checks++; if (data1 !== 32'd0) begin n_fail++; $display("FAIL r0_read: got %0h want 0", data1); end
    n_checks++; if (rs1_busy !== 1'b0) begin n_fail++; $display("FAIL r0_busy: got %0b want 0", rs1_busy); end
    n_checks++; if (data2 !== 32'd2) begin n_fail++; $display("FAIL r0_port2_r2: got %0h want 2", data2); end
  endtask

  task automatic test_forwarding();
    idle();
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'h1234;
    rd_en = 1'b1; rs1_addr = 4'd5; rs2_addr = 4'd3;
    dbg_addr = 4'd5;
    tick();
    n_checks++; if (data1 !== (BYP ? 32'h1234 : 32'h0)) begin n_fail++; $display("FAIL fwd_data1: got %0h want %0h", data1, BYP ? 32'h1234 : 32'h0); end
    n_checks++; if (dbg_data !== (BYP ? 32'h1234 : 32'h0)) begin n_fail++; $display("FAIL fwd_dbg: got %0h want %0h", dbg_data, BYP ? 32'h1234 : 32'h0); end
    n_checks++; if (data2 !== 32'd349) begin n_fail++; $display("FAIL fwd_data2: got %0h want 15d", data2); end
    idle();
    rd_en = 1'b1; rs1_addr = 4'd3; rs2_addr = 4'd5;
    tick();
    n_checks++; if (data2 !== 32'h1234) begin n_fail++; $display("FAIL fwd_after: got %0h want 1234", data2); end
    n_checks++; if (dbg_data !== 32'h1234) begin n_fail++; $display("FAIL fwd_dbg_after: got %0h want 1234", dbg_data); end
    dbg_addr = 4'd13;
  endtask

  task automatic test_write_reserve();
    idle();
    rsv_en = 1'b1; rsv_addr = 4'd7;
    rd_en = 1'b1; rs1_addr = 4'd7; rs2_addr = 4'd6;
    tick();
    n_checks++; if (rs1_busy !== 1'b1) begin n_fail++; $display("FAIL rsv_step1_busy: got %0b want 1", rs1_busy); end
    n_checks++; if (rs2_busy !== 1'b0) begin n_fail++; $display("FAIL rsv_step1_other: got %0b want 0", rs2_busy); end
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'h77;
    rsv_en = 1'b1; rsv_addr = 4'd7;
    rs1_addr = 4'd7; rs2_addr = 4'd7;
    tick();
    n_checks++; if (rs1_busy !== 1'b1) begin n_fail++; $display("FAIL rsv_step2_busy: got %0b want 1", rs1_busy); end
    idle();
    rd_en = 1'b1; rs1_addr = 4'd7; rs2_addr = 4'd7;
    tick();
    n_checks++; if (rs2_busy !== 1'b1) begin n_fail++; $display("FAIL rsv_step2_hold: got %0b want 1", rs2_busy); end
    n_checks++; if (data1 !== 32'h77) begin n_fail++; $display("FAIL rsv_step2_data: got %0h want 77", data1); end
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'h78;
    tick();
    n_checks++; if (rs1_busy !== (BYP ? 1'b0 : 1'b1)) begin n_fail++; $display("FAIL rsv_step3_same: got %0b want %0b", rs1_busy, BYP ? 1'b0 : 1'b1); end
    n_checks++; if (data1 !== (BYP ? 32'h78 : 32'h77)) begin n_fail++; $display("FAIL rsv_step3_data: got %0h want %0h", data1, BYP ? 32'h78 : 32'h77); end
    idle();
    rd_en = 1'b1; rs1_addr = 4'd7; rs2_addr = 4'd7;
    tick();
    n_checks++; if (rs1_busy !== 1'b0) begin n_fail++; $display("FAIL rsv_step3_busy: got %0b want 0", rs1_busy); end
    n_checks++; if (data2 !== 32'h78) begin n_fail++; $display("FAIL rsv_step3_after: got %0h want 78", data2); end
  endtask

  task automatic test_async_reset();
    idle();
    rsv_en = 1'b1; rsv_addr = 4'd4;
    rd_en = 1'b1; rs1_addr = 4'd4; rs2_addr = 4'd2;
    tick();
    n_checks++; if (rs1_busy !== 1'b1) begin n_fail++; $display("FAIL arst_pre_busy: got %0b want 1", rs1_busy); end
    rsv_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL arst_rd_valid: got %0b want 0", rd_valid); end
    n_checks++; if ({rs1_busy, rs2_busy} !== 2'b00) begin n_fail++; $display("FAIL arst_busy: got %0b%0b want 00", rs1_busy, rs2_busy); end
    n_checks++; if (data2 !== 32'd0) begin n_fail++; $display("FAIL arst_data2: got %0h want 0", data2); end
    #2;
    rst_n = 1'b1;
    tick();
    n_checks++; if (rs1_busy !== 1'b0) begin n_fail++; $display("FAIL arst_r4_busy: got %0b want 0", rs1_busy); end
    n_checks++; if (data2 !== 32'd2) begin n_fail++; $display("FAIL arst_r2_image: got %0h want 2", data2); end
    rs1_addr = 4'd5; rs2_addr = 4'd7;
    tick();
    n_checks++; if (data1 !== 32'd0) begin n_fail++; $display("FAIL arst_r5_cleared: got %0h want 0", data1); end
    n_checks++; if (data2 !== 32'd0) begin n_fail++; $display("FAIL arst_r7_cleared: got %0h want 0", data2); end
  endtask

  task automatic test_param();
    idle();
    dbg_addr_w = 5'd31;
    wr_en_w = 1'b1; wr_addr_w = 5'd31; wr_data_w = 64'hFFFF_FFFF_0000_0001;
    rd_en_w = 1'b1; rs1_addr_w = 5'd31; rs2_addr_w = 5'd3;
    tick();
    n_checks++; if (dbg_data_w !== (BYP ? 64'hFFFF_FFFF_0000_0001 : 64'h0)) begin n_fail++; $display("FAIL wide_dbg_same: got %0h want %0h", dbg_data_w, BYP ? 64'hFFFF_FFFF_0000_0001 : 64'h0); end
    n_checks++; if (data2_w !== 64'd349) begin n_fail++; $display("FAIL wide_r3: got %0h want 15d", data2_w); end
    wr_en_w = 1'b0;
    tick();
    n_checks++; if (dbg_data_w !== 64'hFFFF_FFFF_0000_0001) begin n_fail++; $display("FAIL wide_dbg: got %0h want ffffffff00000001", dbg_data_w); end
    n_checks++; if (data1_w !== 64'hFFFF_FFFF_0000_0001) begin n_fail++; $display("FAIL wide_r31: got %0h want ffffffff00000001", data1_w); end
    n_checks++; if (rd_valid_w !== 1'b1) begin n_fail++; $display("FAIL wide_valid: got %0b want 1", rd_valid_w); end
  endtask

  initial begin
    test_reset();
    test_r0();
    test_forwarding();
    test_write_reserve();
    test_async_reset();
    test_param();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_bank_param.md
# reg_bank_param

Parametrised general-purpose register file for the processor datapath: a generalised successor to the fixed 16×32 bank. It provides a configurable register count and width, two synchronous read ports with a valid strobe, one write port, a hard-wired zero register, a selectable debug read port, and a per-register pending scoreboard. The decode stage uses the scoreboard to detect read-after-write hazards on multi-cycle results. It sits between decode (read/reserve) and writeback (write/clear).

## Interface
- NUM_REGS, 16, number of registers; power of two, ≥ 4
- DATA_W, 32, register width in bits
- AW, $clog2(NUM_REGS), address width (derived; not overridden)
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- rd_en  in  1  read request for rs1_addr/rs2_addr this cycle
- rs1_addr  in  AW  read port 1 address
- rs2_addr  in  AW  read port 2 address
- data1  out  DATA_W  port 1 read data
- data2  out  DATA_W  port 2 read data
- rs1_busy  out  1  rs1 register pending at read time
- rs2_busy  out  1  rs2 register pending at read time
- rd_valid  out  1  data1/data2/busy valid
- wr_en  in  1  write enable
- wr_addr  in  AW  write address
- wr_data  in  DATA_W  write data
- rsv_en  in  1  mark rsv_addr pending (result in flight)
- rsv_addr  in  AW  register to reserve
- dbg_addr  in  AW  debug read address
- dbg_data  out  DATA_W  debug read data (registered)

## Operation
- Storage: NUM_REGS × DATA_W array, plus a NUM_REGS-bit pending vector.
- Reset (rst_n low, asynchronous):
  - Array loaded from the reset image: R2 = 2, R3 = 349, all others 0.
  - Pending vector cleared.
  - data1, data2, dbg_data = 0; rd_valid, rs1_busy, rs2_busy = 0.
- R0 hard-wired:
  - Reads return 0.
  - Writes to R0 are dropped.
  - Reservations of R0 are dropped; R0 is never busy.
- Write: wr_en && wr_addr ≠ 0 stores wr_data and clears pending[wr_addr].
- Reserve: rsv_en && rsv_addr ≠ 0 sets pending[rsv_addr].
- Write and reserve to the same register in the same cycle:
  - Data is written.
  - Pending ends set, because the reservation belongs to a newer producer.
- Read: on rd_en, the rising edge registers:
  - data1/data2 from the array, or the bypassed value (see Configuration).
  - rs1_busy/rs2_busy from pending_next[rs], where pending_next = (pending & ~clear) | set.
  - rd_valid = 1.
- Without rd_en: rd_valid = 0; data and busy outputs hold their last values.
- dbg_data: registered every cycle from dbg_addr and follows the same bypass rule. It replaces the fixed R13 debug tap; the top level ties dbg_addr to 13.
- Out-of-range addresses cannot occur, because AW exactly spans NUM_REGS.

## Timing
- Read latency is 1 cycle: address and rd_en are presented in cycle N; data, busy and rd_valid are valid after edge N+1.
- Write is visible in the array after its edge.
- Same-cycle read of the register being written is covered by Configuration.
- The pending set/clear takes effect at the edge.
- Busy outputs sampled in the same cycle already include that cycle's set/clear.
- All reads use the rising edge only; no negedge logic.
- Reset is asserted asynchronously and released synchronously to clk by the upstream reset synchroniser.
- Reset mid-operation:
  - All in-flight reads are discarded (rd_valid = 0).
  - All reservations are cleared.

## Configuration
- REG_BANK_BYPASS_EN defined:
  - A same-cycle read of wr_addr (≠ 0, wr_en high) returns wr_data on data1/data2/dbg_data.
  - The corresponding busy bit reflects pending_next.
- REG_BANK_BYPASS_EN undefined:
  - The same read returns the pre-write array value.
  - Busy uses pending before the write's clear. The reservation set is still included.
  - Decode must stall one cycle on that case.

## Structure
- Package reg_bank_pkg holds:
  - The reset-image constants: RST_R2 = 2, RST_R3 = 349, default 0.
  - A function returning the reset value for an index.
- Sub-module reg_scoreboard owns the pending vector.
  - Inputs: set/clear ports and two query addresses.
  - Outputs: pending_next bits.
- The top module holds the array, the bypass muxes and the output registers.

## Test plan
- Reset values: assert rst_n = 0, then release; read R2/R3 → data1 = 2, data2 = 349, rd_valid = 1 one cycle after rd_en, busy = 0.
- R0 protection: write 0xDEADBEEF to R0 and reserve R0, then read R0 → data 0, busy 0.
- Forwarding (bypass on): in the same cycle write R5 = 0x1234 and read rs1 = 5 → data1 = 0x1234 next cycle. With bypass off → old value 0.
- Write/reserve in the same cycle:
  - Step 1: reserve R7 → a read shows rs1_busy = 1.
  - Step 2: write R7 and reserve R7 in the same cycle → busy stays 1.
  - Step 3: write R7 alone → busy 0.
- Async reset mid-operation: reserve R4, issue rd_en, then drop rst_n between edges → outputs 0 immediately and pending cleared; after release, reading R4 → busy 0.
- Parametrisation: NUM_REGS = 32, DATA_W = 64; write R31 = 0xFFFF_FFFF_0000_0001; dbg_addr = 31 → dbg_data matches one cycle later.
